// File: rtl/cska_multiword_adder.sv
// Multi-cycle W-bit adder built around a CHUNK-bit carry-skip adder core.
// Operands are summed one chunk per cycle, LSB first, with a registered carry.

module cska_top #(
    parameter int N          = 2,
    parameter int BLOCK_SIZE = 2
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N-1:0] p;
    logic [N-1:0] g;
    logic         c_rip;
    logic         c_blk;
    logic         blk_p;

    assign p = a ^ b;
    assign g = a & b;

    // Ripple inside each block; a fully propagating block forwards its carry-in.
    always_comb begin
        sum   = '0;
        c_rip = cin;
        c_blk = cin;
        blk_p = 1'b1;
        for (int i = 0; i < N; i++) begin
            sum[i] = p[i] ^ c_rip;
            c_rip  = g[i] | (p[i] & c_rip);
            blk_p  = blk_p & p[i];
            if ((i % BLOCK_SIZE) == BLOCK_SIZE - 1 || i == N - 1) begin
                c_blk = blk_p ? c_blk : c_rip;
                c_rip = c_blk;
                blk_p = 1'b1;
            end
        end
        cout = c_blk;
    end

endmodule

module cska_multiword_adder #(
    parameter int W          = 8,
    parameter int CHUNK      = 2,
    parameter int BLOCK_SIZE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         busy
);

    localparam int NCHUNK = W / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (W % CHUNK != 0) begin : g_width_chk
        $error("cska_multiword_adder: W must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;

    assign chunk_a = a_q[idx_q*CHUNK +: CHUNK];
    assign chunk_b = b_q[idx_q*CHUNK +: CHUNK];

    cska_top #(
        .N          (CHUNK),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_core (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = in_a;
                    b_d        = in_b;
                    carry_d    = in_cin;
                    idx_d      = '0;
                    state_d    = CALC;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            CALC: begin
                sum_d[idx_q*CHUNK +: CHUNK] = chunk_sum;
                carry_d = chunk_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(NCHUNK - 1)) begin
                    idx_d       = '0;
                    cout_d      = chunk_cout;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cska_multiword_adder.sv
// Directed and random checks of the chunked carry-skip adder wrapper.

module tb_cska_multiword_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_cout;
    logic       busy;

    int checks = 0;
    int errors = 0;

    cska_multiword_adder #(
        .W          (8),
        .CHUNK      (2),
        .BLOCK_SIZE (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c);
        in_a = a;
        in_b = b;
        in_cin = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        in_cin = 1'($urandom);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, out_sum, out_cout, busy} !== 12'b1_0_00000000_0_0) begin
            errors++;
            $display("FAIL reset: got rdy=%b vld=%b sum=%h co=%b busy=%b, want 1 0 00 0 0",
                     in_ready, out_valid, out_sum, out_cout, busy);
        end
    endtask

    task automatic test_vector(input logic [7:0] a, input logic [7:0] b, input logic c,
                               input logic [7:0] es, input logic ec);
        int n;
        send(a, b, c);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL accept %h+%h: rdy=%b busy=%b, want 0 1", a, b, in_ready, busy);
        end
        wait_valid(n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL latency %h+%h: got %0d cycles, want 4", a, b, n);
        end
        checks++;
        if (out_sum !== es || out_cout !== ec || busy !== 1'b1) begin
            errors++;
            $display("FAIL vec %h+%h+%b: got %b_%h busy=%b, want %b_%h busy=1",
                     a, b, c, out_cout, out_sum, busy, ec, es);
        end
    endtask

    task automatic test_handshake(input logic [7:0] es);
        ack();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_sum !== es) begin
            errors++;
            $display("FAIL handshake: vld=%b rdy=%b busy=%b sum=%h, want 0 1 0 %h",
                     out_valid, in_ready, busy, out_sum, es);
        end
    endtask

    task automatic test_backpressure();
        test_vector(8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = 8'h55;
            in_b = 8'h66;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 8'h01 || out_cout !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: vld=%b sum=%h co=%b rdy=%b, want 1 01 0 0",
                         i, out_valid, out_sum, out_cout, in_ready);
            end
        end
        in_valid = 1'b0;
        test_handshake(8'h01);
    endtask

    task automatic test_reset_mid();
        send(8'h12, 8'h34, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, out_sum, out_cout, busy} !== 12'b1_0_00000000_0_0) begin
            errors++;
            $display("FAIL midreset: rdy=%b vld=%b sum=%h co=%b busy=%b, want 1 0 00 0 0",
                     in_ready, out_valid, out_sum, out_cout, busy);
        end
        test_vector(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        test_handshake(8'h46);
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [3] = '{8'h7F, 8'hC3, 8'h0F};
        logic [7:0] vb [3] = '{8'h01, 8'h3D, 8'hF0};
        logic       vc [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] es [3] = '{8'h80, 8'h01, 8'hFF};
        logic       ec [3] = '{1'b0, 1'b1, 1'b0};
        int n;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = va[i];
            in_b = vb[i];
            in_cin = vc[i];
            tick();
            in_a = 8'hEE;
            in_b = 8'hDD;
            wait_valid(n);
            checks++;
            if (n !== 4 || out_sum !== es[i] || out_cout !== ec[i]) begin
                errors++;
                $display("FAIL b2b%0d: lat=%0d got %b_%h, want lat=4 %b_%h",
                         i, n, out_cout, out_sum, ec[i], es[i]);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: vld=%b rdy=%b, want 0 1", i, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        logic       c;
        logic [8:0] exp;
        int n;
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            c = 1'($urandom);
            exp = {1'b0, a} + {1'b0, b} + {8'b0, c};
            send(a, b, c);
            wait_valid(n);
            checks++;
            if (n !== 4 || {out_cout, out_sum} !== exp) begin
                errors++;
                $display("FAIL rand%0d %h+%h+%b: lat=%0d got %b_%h, want %b_%h",
                         i, a, b, c, n, out_cout, out_sum, exp[8], exp[7:0]);
            end
            ack();
        end
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        out_ready = 1'b0;
        #2;
        test_reset();
        test_vector(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        test_handshake(8'h00);
        test_vector(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        test_handshake(8'h00);
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
